aes_key_schedule: RTL and testbench

- Iterative AES key expansion engine (FIPS-197) for AES-128, AES-192 and AES-256.
- Presents one 128-bit round key per enabled clock, in round order 0..Nr.
- Sits beside the AES round datapath, which consumes ks_o in lock-step with its rounds.
- Loaded once per key or key size, then stepped with en_i.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_sbox_word.sv | 17 +
 rtl/aes_key_schedule.sv | 137 +++++++++++++
 tb/tb_aes_key_schedule.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size encodings, rcon seed, S-box table and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } key_size_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Byte-wise substitution.
    always_comb begin
        word_o = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = sub_byte(word_i[8*b +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion; one 128-bit round key per enabled clock.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [1:0]   size_i,
    input  logic [255:0] key_i,
    output logic [127:0] ks_o
);

    // win_q holds the last 8 known schedule words, oldest in [0], newest in [7].
    logic [31:0]  win_q [8];
    logic [31:0]  win_d [8];
    logic [2:0]   pos_q, pos_d;      // (index of next word to compute) mod Nk
    logic [7:0]   rcon_q, rcon_d;
    key_size_e    size_q, size_d;
    logic [127:0] ks_q, ks_d;

    key_size_e    size_sel;
    logic [31:0]  nw [4];
    logic [31:0]  prev, t;
    logic [2:0]   p;
    logic         rcon_used;
    logic [31:0]  sub_in, sub_out, sub_rot;

    function automatic int unsigned nk_of(input key_size_e s);
        case (s)
            AES192:  return 6;
            AES256:  return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] wrap(input logic [3:0] v, input key_size_e s);
        case (s)
            AES192:  return (v >= 4'd6) ? 3'(v - 4'd6) : v[2:0];
            AES256:  return v[2:0];
            default: return {1'b0, v[1:0]};
        endcase
    endfunction

    assign size_sel = (size_i == 2'b01) ? AES192 :
                      (size_i == 2'b10) ? AES256 : AES128;

    // The only SubWord in a step always lands on chain slot 0, except AES-192 at
    // position 4 where it lands on slot 2; that input is formed directly from the
    // window (w[k+1] = win2^win3^win7) so the S-box never sits inside the chain loop.
    assign sub_in  = (size_q == AES192 && pos_q == 3'd4) ? (win_q[2] ^ win_q[3] ^ win_q[7])
                                                          : win_q[7];
    assign sub_rot = {sub_out[23:0], sub_out[31:24]};

    aes_sbox_word u_sbox (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    // Four-word recurrence chain for the next step.
    always_comb begin
        nw        = '{default: '0};
        prev      = win_q[7];
        t         = '0;
        p         = '0;
        rcon_used = 1'b0;
        for (int unsigned j = 0; j < 4; j++) begin
            p = wrap(4'(pos_q) + 4'(j), size_q);
            if (p == 3'd0) begin
                t         = sub_rot ^ {rcon_q, 24'h0};
                rcon_used = 1'b1;
            end else if (size_q == AES256 && p == 3'd4) begin
                t = sub_out;
            end else begin
                t = prev;
            end
            nw[j] = win_q[3'(8 - nk_of(size_q) + j)] ^ t;
            prev  = nw[j];
        end
    end

    // Next state: load restarts at round key 0, step slides the window by 4 words.
    always_comb begin
        win_d  = win_q;
        pos_d  = pos_q;
        rcon_d = rcon_q;
        size_d = size_q;
        ks_d   = ks_q;
        if (load_i) begin
            size_d = size_sel;
            win_d  = '{default: '0};
            for (int unsigned m = 0; m < 8; m++) begin
                if (m < nk_of(size_sel)) begin
                    win_d[3'(8 - nk_of(size_sel) + m)] = key_i[255 - 32*m -: 32];
                end
            end
            ks_d   = key_i[255:128];
            pos_d  = '0;
            rcon_d = RCON_INIT;
        end else if (en_i) begin
            // Output lags the newest known word by Nk-4 words of lookahead.
            case (size_q)
                AES192:  ks_d = {win_q[6], win_q[7], nw[0], nw[1]};
                AES256:  ks_d = {win_q[4], win_q[5], win_q[6], win_q[7]};
                default: ks_d = {nw[0], nw[1], nw[2], nw[3]};
            endcase
            for (int unsigned m = 0; m < 4; m++) begin
                win_d[3'(m)]     = win_q[3'(m + 4)];
                win_d[3'(m + 4)] = nw[m];
            end
            pos_d = wrap(4'(pos_q) + 4'd4, size_q);
            if (rcon_used) begin
                rcon_d = xtime(rcon_q);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q  <= '{default: '0};
            pos_q  <= '0;
            rcon_q <= RCON_INIT;
            size_q <= AES128;
            ks_q   <= '0;
        end else begin
            win_q  <= win_d;
            pos_q  <= pos_d;
            rcon_q <= rcon_d;
            size_q <= size_d;
            ks_q   <= ks_d;
        end
    end

    assign ks_o = ks_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench: FIPS-197 style key expansion model, FIPS vectors and random traffic.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_i = 1'b0;
    logic         en_i = 1'b0;
    logic [1:0]   size_i = 2'b00;
    logic [255:0] key_i = '0;
    logic [127:0] ks_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sb [256];
    logic [31:0] mw [128];
    int          m_r = 0;
    bit          m_valid = 1'b0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_schedule dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_i),
        .en_i   (en_i),
        .size_i (size_i),
        .key_i  (key_i),
        .ks_o   (ks_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // FIPS-197 KeyExpansion pseudo-code, run past Nr to cover continued stepping.
    task automatic expand(input logic [255:0] key, input logic [1:0] sz);
        int nk;
        logic [31:0] temp;
        logic [7:0] rc;
        nk = (sz == 2'b01) ? 6 : (sz == 2'b10) ? 8 : 4;
        for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 128; i++) begin
            temp = mw[i-1];
            if (i % nk == 0) begin
                temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                temp = subword(temp);
            end
            mw[i] = mw[i-nk] ^ temp;
        end
    endtask

    function automatic logic [127:0] exp_ks();
        return {mw[4*m_r], mw[4*m_r+1], mw[4*m_r+2], mw[4*m_r+3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Drive one cycle, then advance the model with the same inputs the DUT sampled.
    task automatic step(input logic rst, input logic ld, input logic en,
                        input logic [1:0] sz, input logic [255:0] key);
        rst_n  = rst;
        load_i = ld;
        en_i   = en;
        size_i = sz;
        key_i  = key;
        @(posedge clk);
        #1;
        if (!rst) begin
            expand('0, 2'b00);
            m_r = 0;
            m_valid = 1'b1;
        end else if (ld) begin
            expand(key, sz);
            m_r = 0;
            m_valid = 1'b1;
        end else if (en) begin
            m_r++;
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Continuous comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (m_valid) chk("ks_o", ks_o, exp_ks());
    end

    initial begin
        logic [255:0] key;
        logic [1:0]   sz;
        int           n;
        build_sbox();

        step(1'b0, 1'b0, 1'b0, 2'b00, '0);
        step(1'b0, 1'b1, 1'b1, 2'b10, K256);
        chk("reset_ks", ks_o, 128'h0);

        // AES-128, load with en_i high.
        step(1'b1, 1'b1, 1'b1, 2'b00, K128);
        chk("r0_128", ks_o, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 2'(i), rnd256());
            if (i == 1)  chk("r1_128", ks_o, 128'ha0fafe1788542cb123a339392a6c7605);
            if (i == 10) chk("r10_128", ks_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end

        // Hold mid-schedule.
        step(1'b1, 1'b1, 1'b0, 2'b00, K128);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 2'b00, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 2'b10, rnd256());
            chk("hold", ks_o, exp_ks());
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 2'b00, '0);
        chk("r10_128_hold", ks_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192.
        step(1'b1, 1'b1, 1'b0, 2'b01, K192);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 1'b1, 2'b00, '0);
            if (i == 1)  chk("r1_192", ks_o, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
            if (i == 12) chk("r12_192", ks_o, 128'he98ba06f448c773c8ecc720401002202);
        end

        // AES-256.
        step(1'b1, 1'b1, 1'b0, 2'b10, K256);
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 1'b0, 1'b1, 2'b00, '0);
            if (i == 1)  chk("r1_256", ks_o, 128'h1f352c073b6108d72d9810a30914dff4);
            if (i == 2)  chk("r2_256", ks_o, 128'h9ba354118e6925afa51a8b5f2067fcde);
            if (i == 14) chk("r14_256", ks_o, 128'hfe4890d1e6188d0b046df344706c631e);
        end

        // Reload with load_i and en_i together mid AES-256.
        step(1'b1, 1'b1, 1'b0, 2'b10, K256);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 2'b00, '0);
        step(1'b1, 1'b1, 1'b1, 2'b00, K128);
        chk("reload_r0", ks_o, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        step(1'b1, 1'b0, 1'b1, 2'b00, '0);
        chk("reload_r1", ks_o, 128'ha0fafe1788542cb123a339392a6c7605);

        // Size code 11 behaves as 128-bit.
        step(1'b1, 1'b1, 1'b0, 2'b11, K128);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 2'b10, rnd256());
        chk("r10_size3", ks_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset mid-schedule, then step without a load.
        step(1'b1, 1'b1, 1'b0, 2'b10, K256);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 2'b00, '0);
        step(1'b0, 1'b0, 1'b1, 2'b10, K256);
        chk("rst_mid", ks_o, 128'h0);
        step(1'b1, 1'b0, 1'b1, 2'b10, K256);
        chk("zero_r1", ks_o, 128'h62636363626363636263636362636363);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 2'b01, rnd256());

        // Random keys, sizes, enables, garbage on key/size between loads.
        for (int it = 0; it < 40; it++) begin
            key = rnd256();
            sz  = 2'($urandom_range(0, 3));
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)), sz, key);
            n = $urandom_range(4, 18);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    step(1'b0, 1'b0, 1'b1, 2'($urandom()), rnd256());
                end else if ($urandom_range(0, 19) == 0) begin
                    step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom()), rnd256());
                end else begin
                    step(1'b1, 1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom()), rnd256());
                end
            end
        end

        step(1'b1, 1'b0, 1'b0, 2'b00, '0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
